// File: rtl/an_barrett_decoder_pipe.sv
// an_barrett_decoder_pipe
//   Pipelined multi-lane AN-code decoder. Each lane receives y = A*x + e,
//   splits it into quotient and residue with Barrett reduction, and uses the
//   residue as a syndrome to undo a single arithmetic error e = +/-2^i.
//   Stages: S1 input register, S2 Barrett estimate, S3 residue fix-up,
//   then syndrome lookup feeding the output register.
//   A single global stall (out_valid & ~out_ready) freezes every stage.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_word holds LANES codewords
//   corr_en             1 = correct, 0 = detect only (travels with the beat)
//   out_valid/out_ready output handshake
//   out_data            LANES decoded words
//   out_det/corr/uncor  per-lane status: residue != 0 / corrected / uncorrectable
//   clr_cnt             synchronous clear of both event counters
//   cnt_corr/cnt_uncor  saturating counts of corrected / uncorrectable lanes
module an_barrett_decoder_pipe #(
    parameter int unsigned A     = 29,
    parameter int unsigned CW    = 14,
    parameter int unsigned DW    = 10,
    parameter int unsigned LANES = 6,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned K     = 2 * CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*CW-1:0]   in_word,
    input  logic                  corr_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      out_det,
    output logic [LANES-1:0]      out_corr,
    output logic [LANES-1:0]      out_uncor,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      cnt_corr,
    output logic [CNT_W-1:0]      cnt_uncor
);

    // Barrett constant M = floor(2^K / A) and derived widths.
    localparam logic [63:0] M64 = (64'd1 << K) / 64'(A);
    localparam int unsigned MW  = $clog2(M64 + 64'd1);
    localparam int unsigned PW  = CW + MW;
    localparam int unsigned RW  = $clog2(A);   // A odd and >= 3, so A-1 < 2^RW
    localparam int unsigned XW  = CW + 2;      // signed room for q + adjust

    localparam logic [MW-1:0] M_C = M64[MW-1:0];
    localparam logic [CW-1:0] A_W = CW'(A);

    // Syndrome residue of +2^i (neg = 0) or -2^i (neg = 1).
    function automatic logic [RW-1:0] syn_res(input int unsigned i, input logic neg);
        logic [63:0] p;
        logic [63:0] m;
        p = 64'd1 << i;
        m = p % 64'(A);
        if (neg) begin
            m = (64'(A) - m) % 64'(A);
        end
        return m[RW-1:0];
    endfunction

    // Quotient adjustment: -floor(2^i/A) for +2^i, +ceil(2^i/A) for -2^i.
    function automatic logic signed [XW-1:0] syn_adj(input int unsigned i, input logic neg);
        logic [63:0] p;
        logic [63:0] v;
        p = 64'd1 << i;
        if (neg) begin
            v = (p + 64'(A) - 64'd1) / 64'(A);
        end else begin
            v = p / 64'(A);
        end
        return neg ? $signed(v[XW-1:0]) : -$signed(v[XW-1:0]);
    endfunction

    logic stall;

    logic                     s1_valid, s2_valid, s3_valid;
    logic                     s1_ce, s2_ce, s3_ce;
    logic [LANES-1:0][CW-1:0] s1_y, s2_y, s2_q, s3_q;
    logic [LANES-1:0][RW-1:0] s3_r;

    logic [LANES-1:0][CW-1:0] q_est;
    logic [LANES-1:0][CW-1:0] q_fix;
    logic [LANES-1:0][RW-1:0] r_fix;
    logic [LANES-1:0][DW-1:0] d_data;
    logic [LANES-1:0]         d_det, d_corr, d_uncor;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // S2: q_est = (y * M) >> K, full-width product.
    logic [PW-1:0] prod;
    always_comb begin
        prod  = '0;
        q_est = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            prod     = PW'(s1_y[n]) * PW'(M_C);
            q_est[n] = CW'(prod >> K);
        end
    end

    // S3: residue with a single correction step (q_est is at most one low).
    logic [CW:0] diff;
    always_comb begin
        diff  = '0;
        q_fix = '0;
        r_fix = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            diff = (CW+1)'(s2_y[n]) - (CW+1)'(s2_q[n] * A_W);
            if (diff >= (CW+1)'(A)) begin
                r_fix[n] = RW'(diff - (CW+1)'(A));
                q_fix[n] = s2_q[n] + CW'(1);
            end else begin
                r_fix[n] = RW'(diff);
                q_fix[n] = s2_q[n];
            end
        end
    end

    // Syndrome lookup and per-lane decision. The scan runs from i = 0 upward
    // and tests +2^i before -2^i, so the first hit is the one that wins.
    logic                 hit;
    logic signed [XW-1:0] adj;
    logic signed [XW-1:0] x;
    logic                 x_ok;
    always_comb begin
        hit     = 1'b0;
        adj     = '0;
        x       = '0;
        x_ok    = 1'b0;
        d_data  = '0;
        d_det   = '0;
        d_corr  = '0;
        d_uncor = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            hit = 1'b0;
            adj = '0;
            for (int unsigned i = 0; i < CW; i++) begin
                if (!hit && s3_r[n] == syn_res(i, 1'b0)) begin
                    hit = 1'b1;
                    adj = syn_adj(i, 1'b0);
                end
                if (!hit && s3_r[n] == syn_res(i, 1'b1)) begin
                    hit = 1'b1;
                    adj = syn_adj(i, 1'b1);
                end
            end
            x    = $signed({2'b00, s3_q[n]}) + adj;
            x_ok = !x[XW-1] && (($unsigned(x) >> DW) == '0);

            d_data[n] = DW'(s3_q[n]);
            if (s3_r[n] == '0) begin
                d_uncor[n] = ((s3_q[n] >> DW) != '0);
            end else begin
                d_det[n] = 1'b1;
                if (s3_ce) begin
                    if (hit && x_ok) begin
                        d_data[n] = DW'($unsigned(x));
                        d_corr[n] = 1'b1;
                    end else begin
                        d_uncor[n] = 1'b1;
                    end
                end
            end
        end
    end

    // Pipeline registers; everything holds while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_ce     <= 1'b0;
            s2_ce     <= 1'b0;
            s3_ce     <= 1'b0;
            s1_y      <= '0;
            s2_y      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s3_r      <= '0;
            out_data  <= '0;
            out_det   <= '0;
            out_corr  <= '0;
            out_uncor <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_y  <= in_word;
                s1_ce <= corr_en;
            end
            s2_valid  <= s1_valid;
            s2_y      <= s1_y;
            s2_q      <= q_est;
            s2_ce     <= s1_ce;
            s3_valid  <= s2_valid;
            s3_q      <= q_fix;
            s3_r      <= r_fix;
            s3_ce     <= s2_ce;
            out_valid <= s3_valid;
            out_data  <= d_data;
            out_det   <= d_det;
            out_corr  <= d_corr;
            out_uncor <= d_uncor;
        end
    end

    // Event counters: one extra bit catches the step past all-ones.
    logic [CNT_W:0] sum_corr, sum_uncor;
    always_comb begin
        sum_corr  = {1'b0, cnt_corr}  + (CNT_W+1)'($countones(out_corr));
        sum_uncor = {1'b0, cnt_uncor} + (CNT_W+1)'($countones(out_uncor));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr  <= '0;
            cnt_uncor <= '0;
        end else if (clr_cnt) begin
            cnt_corr  <= '0;
            cnt_uncor <= '0;
        end else if (out_valid && out_ready) begin
            cnt_corr  <= sum_corr[CNT_W]  ? '1 : sum_corr[CNT_W-1:0];
            cnt_uncor <= sum_uncor[CNT_W] ? '1 : sum_uncor[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_an_barrett_decoder_pipe.sv
// tb_an_barrett_decoder_pipe
//   Directed bench for an_barrett_decoder_pipe with A=29, CW=14, DW=10,
//   LANES=6, CNT_W=16. Expected values are hand-derived from the AN code.
module tb_an_barrett_decoder_pipe;

    localparam int unsigned CW    = 14;
    localparam int unsigned DW    = 10;
    localparam int unsigned LANES = 6;
    localparam int unsigned CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*CW-1:0]   in_word;
    logic                  corr_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_data;
    logic [LANES-1:0]      out_det;
    logic [LANES-1:0]      out_corr;
    logic [LANES-1:0]      out_uncor;
    logic                  clr_cnt;
    logic [CNT_W-1:0]      cnt_corr;
    logic [CNT_W-1:0]      cnt_uncor;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    an_barrett_decoder_pipe #(
        .A     (29),
        .CW    (CW),
        .DW    (DW),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .corr_en   (corr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_det   (out_det),
        .out_corr  (out_corr),
        .out_uncor (out_uncor),
        .clr_cnt   (clr_cnt),
        .cnt_corr  (cnt_corr),
        .cnt_uncor (cnt_uncor)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*CW-1:0] pack_y(input int unsigned y0, y1, y2, y3, y4, y5);
        return {CW'(y5), CW'(y4), CW'(y3), CW'(y2), CW'(y1), CW'(y0)};
    endfunction

    function automatic logic [LANES*DW-1:0] pack_d(input int unsigned d0, d1, d2, d3, d4, d5);
        return {DW'(d5), DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    // Stream beat k: lane n carries the clean codeword 29*(10k+n).
    function automatic logic [LANES*CW-1:0] stream_word(input int unsigned k);
        logic [LANES*CW-1:0] w;
        w = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            w[n*CW +: CW] = CW'(29 * (10 * k + n));
        end
        return w;
    endfunction

    function automatic logic [LANES*DW-1:0] stream_data(input int unsigned k);
        logic [LANES*DW-1:0] d;
        d = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            d[n*DW +: DW] = DW'(10 * k + n);
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send one beat (caller sits on a negedge with out_ready = 1), wait for
    // it at the output, check latency and all outputs, then let the output
    // handshake happen with clr_cnt driven to 'clr'.
    task automatic do_beat(input string tag, input logic [LANES*CW-1:0] word, input logic ce,
                           input logic [LANES*DW-1:0] e_data, input logic [LANES-1:0] e_det,
                           input logic [LANES-1:0] e_corr, input logic [LANES-1:0] e_uncor,
                           input logic clr);
        int lat;
        in_valid = 1'b1;
        in_word  = word;
        corr_en  = ce;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_data"}, 64'(out_data), 64'(e_data));
        check({tag, "_det"}, 64'(out_det), 64'(e_det));
        check({tag, "_corr"}, 64'(out_corr), 64'(e_corr));
        check({tag, "_uncor"}, 64'(out_uncor), 64'(e_uncor));
        clr_cnt = clr;
        tick();
        clr_cnt = 1'b0;
    endtask

    logic [LANES*CW-1:0] all149;
    logic [LANES*CW-1:0] all145;
    logic [LANES*DW-1:0] all5;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        all149 = pack_y(149, 149, 149, 149, 149, 149);
        all145 = pack_y(145, 145, 145, 145, 145, 145);
        all5   = pack_d(5, 5, 5, 5, 5, 5);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        corr_en   = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_det, out_corr, out_uncor}), 64'd0);
        check("rst_cnt_corr", 64'(cnt_corr), 64'd0);
        check("rst_cnt_uncor", 64'(cnt_uncor), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Clean codewords: 145 = 29*5
        do_beat("clean", all145, 1'b1, all5, 6'b0, 6'b0, 6'b0, 1'b0);
        check("clean_cnt_corr", 64'(cnt_corr), 64'd0);

        // Syndromes 4 (+2^2), 21 (-2^3), 3 (+2^5) all decode to 5
        do_beat("corr3", pack_y(149, 137, 177, 145, 145, 145), 1'b1, all5,
                6'b000111, 6'b000111, 6'b000000, 1'b0);
        check("corr3_cnt_corr", 64'(cnt_corr), 64'd3);
        check("corr3_cnt_uncor", 64'(cnt_uncor), 64'd0);

        // Detect only
        do_beat("detonly", pack_y(149, 145, 145, 145, 145, 145), 1'b0, all5,
                6'b000001, 6'b000000, 6'b000000, 1'b0);
        check("detonly_cnt_corr", 64'(cnt_corr), 64'd3);
        check("detonly_cnt_uncor", 64'(cnt_uncor), 64'd0);

        // y=3: syndrome 3 -> +2^5, x = 0 - 1 = -1, uncorrectable
        do_beat("neg_x", pack_y(3, 145, 145, 145, 145, 145), 1'b1, pack_d(0, 5, 5, 5, 5, 5),
                6'b000001, 6'b000000, 6'b000001, 1'b0);
        check("neg_x_cnt_corr", 64'(cnt_corr), 64'd3);
        check("neg_x_cnt_uncor", 64'(cnt_uncor), 64'd1);

        // Range edges: 16383 = 29*565 - 2 (syndrome 27), 16356 = 29*564, 0
        do_beat("edges", pack_y(16383, 16356, 0, 145, 145, 145), 1'b1,
                pack_d(565, 564, 0, 5, 5, 5), 6'b000001, 6'b000001, 6'b000000, 1'b0);
        check("edges_cnt_corr", 64'(cnt_corr), 64'd4);
        check("edges_cnt_uncor", 64'(cnt_uncor), 64'd1);

        // Streaming with out_ready low during loop cycles 5..8
        begin
            int unsigned sent = 0;
            int unsigned recv = 0;
            int unsigned extra = 0;
            logic [LANES*DW-1:0] held = '0;
            logic prev_stall = 1'b0;
            for (int c = 0; c < 60 && recv < 10; c++) begin
                out_ready = !(c >= 5 && c <= 8);
                in_valid  = (sent < 10);
                in_word   = stream_word(sent);
                corr_en   = 1'b1;
                #1;
                if (prev_stall) begin
                    check("stall_hold", 64'(out_data), 64'(held));
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                end
                if (out_valid && out_ready) begin
                    check("stream_beat", 64'(out_data), 64'(stream_data(recv)));
                    recv++;
                end
                if (in_valid && in_ready) begin
                    sent++;
                end
                prev_stall = out_valid && !out_ready;
                held = out_data;
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (out_valid) extra++;
                tick();
            end
            check("stream_recv", 64'(recv), 64'd10);
            check("stream_extra", 64'(extra), 64'd0);
            check("stream_cnt_corr", 64'(cnt_corr), 64'd4);
        end

        // Reset in the middle of a stream of fully corrected beats
        begin
            int unsigned stale = 0;
            for (int c = 0; c < 6; c++) begin
                in_valid = 1'b1;
                in_word  = all149;
                corr_en  = 1'b1;
                tick();
            end
            check("pre_rst_cnt_corr", 64'(cnt_corr), 64'd16);
            check("pre_rst_out_valid", 64'(out_valid), 64'd1);
            #2 rst = 1'b1;
            #1;
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            check("midrst_cnt_corr", 64'(cnt_corr), 64'd0);
            check("midrst_cnt_uncor", 64'(cnt_uncor), 64'd0);
            check("midrst_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (out_valid) stale++;
            end
            check("midrst_stale", 64'(stale), 64'd0);
        end

        // Saturation: 10922*6 + 2 = 65534 corrections, then one more full beat
        for (int b = 0; b < 10923; b++) begin
            in_valid = 1'b1;
            in_word  = (b < 10922) ? all149 : pack_y(149, 149, 145, 145, 145, 145);
            corr_en  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("sat_pre_cnt_corr", 64'(cnt_corr), 64'd65534);
        check("sat_pre_cnt_uncor", 64'(cnt_uncor), 64'd0);

        do_beat("sat", all149, 1'b1, all5, 6'b111111, 6'b111111, 6'b000000, 1'b0);
        check("sat_cnt_corr", 64'(cnt_corr), 64'd65535);

        do_beat("sat_hold", all149, 1'b1, all5, 6'b111111, 6'b111111, 6'b000000, 1'b0);
        check("sat_hold_cnt_corr", 64'(cnt_corr), 64'd65535);

        // Clear in the same cycle as a counting handshake
        do_beat("clr", all149, 1'b1, all5, 6'b111111, 6'b111111, 6'b000000, 1'b1);
        check("clr_cnt_corr", 64'(cnt_corr), 64'd0);
        check("clr_cnt_uncor", 64'(cnt_uncor), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/an_barrett_decoder_pipe.md
# an_barrett_decoder_pipe

Pipelined, multi-lane AN-code decoder. Each lane takes a codeword y = A·x + e, computes the residue y mod A and the quotient with Barrett reduction, and corrects single arithmetic-weight errors (e = ±2^i) from the syndrome. It also reports detection and correction status and keeps saturating event counters. It is the clocked, backpressured successor of the combinational per-word decoder array, and sits between the protected-word source and the consumer of the decoded data.

## Interface
- A, default 29: code multiplier; odd, ≥3.
- CW, default 14: codeword width per lane.
- DW, default 10: decoded data width per lane.
- LANES, default 6: parallel lanes.
- CNT_W, default 16: event counter width.
- K, default 2*CW: Barrett shift; M = floor(2^K / A), computed at elaboration.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  decoder accepts beat
- in_word  in  LANES*CW  codewords; lane n at [n*CW +: CW]
- corr_en  in  1  1 = correct, 0 = detect only; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  LANES*DW  decoded data; lane n at [n*DW +: DW]
- out_det  out  LANES  per lane: residue ≠ 0
- out_corr  out  LANES  per lane: correction applied
- out_uncor  out  LANES  per lane: uncorrectable
- clr_cnt  in  1  synchronous clear of both counters
- cnt_corr  out  CNT_W  saturating count of corrected lanes
- cnt_uncor  out  CNT_W  saturating count of uncorrectable lanes

## Operation
- S1: register in_word and corr_en.
- S2: q_est = (y·M) >> K. Product width CW + width(M); no truncation.
- S3: r = y − q_est·A. If r ≥ A, then r −= A and q = q_est + 1. One fix step suffices for K = 2·CW.
- S4: syndrome table, built at elaboration, for i in 0..CW−1:
  - +2^i: residue 2^i mod A, quotient adjust −floor(2^i/A)
  - −2^i: residue (A − 2^i mod A) mod A, quotient adjust +ceil(2^i/A)
  - On duplicate residues the lowest i wins, and + wins over −.
- Per-lane result:
  - r = 0: data = q; det = corr = uncor = 0. If q > 2^DW−1, uncor = 1 and data = q[DW−1:0].
  - r ≠ 0, corr_en = 1, match found: x = q + adjust. If 0 ≤ x ≤ 2^DW−1: data = x, det = corr = 1. Otherwise: data = q[DW−1:0], det = uncor = 1, corr = 0.
  - r ≠ 0, no match: data = q[DW−1:0], det = uncor = 1.
  - r ≠ 0, corr_en = 0: data = q[DW−1:0], det = 1, corr = uncor = 0.
- Counters:
  - On each output handshake (out_valid & out_ready), cnt_corr += popcount(out_corr) and cnt_uncor += popcount(out_uncor).
  - Both saturate at 2^CNT_W−1.
  - clr_cnt has priority over an increment in the same cycle.

## Timing
- Latency: 4 cycles from input handshake to out_valid for that beat (S1–S3 plus output register). Throughput: 1 beat/cycle.
- Global stall: stall = out_valid & ~out_ready; in_ready = ~stall. During stall every stage register and valid bit holds, and out_* stay stable.
- An input beat is accepted only when in_valid & in_ready.
- Reset values: all valid bits 0, out_valid 0, out_data 0, out_det/out_corr/out_uncor 0, counters 0. in_ready is 1 while rst is asserted and after it is released.
- Reset mid-stream drops all in-flight beats; no output follows from them.
- Bubbles (in_valid = 0) propagate as out_valid = 0 and do not touch the counters.

## Test plan
- A=29, all lanes y=145 (x=5), corr_en=1 -> after 4 cycles out_data=5 on all lanes, det=corr=uncor=0.
- Lane0 y=149, lane1 y=137, lane2 y=177, corr_en=1 -> all three lanes give 5 with det=corr=1 (syndromes 4, 21, 3 map to +2^2, −2^3, +2^5). cnt_corr advances by 3.
- Lane0 y=149, corr_en=0 -> out_data=5, det=1, corr=0, uncor=0; counters unchanged.
- Lane0 y=3 (syndrome 3 → +2^5, x=−1) -> det=1, uncor=1, corr=0, out_data=0; cnt_uncor += 1.
- Stream 10 beats with out_ready low for cycles 5–8 -> no beat lost or duplicated, outputs stable while stalled, in_ready=0 during the stall. Assert rst mid-stream -> out_valid=0 and counters=0 in the same cycle, and no stale beats appear afterwards.
- Force cnt_corr to 2^CNT_W−2 and send a beat with 6 corrections -> counter saturates at 2^CNT_W−1. clr_cnt together with a handshake -> counter reads 0 next cycle.
